fpga_rst_boot_seq: RTL and testbench
====================================

FPGA_RST_BOOT_SEQ -- requirements
Module: fpga_rst_boot_seq

Interface
REQ-001 The block SHALL have parameter LOCK_STABLE, default 16, giving the number of consecutive synchronized lock-high cycles required before reset hold starts.
REQ-002 The block SHALL have parameter RST_HOLD_CYCLES, default 1024, giving the number of cycles the SoC reset is held after lock qualifies.
REQ-003 The block SHALL have parameter BLINK_BIT, default 24, giving the free-running counter bit used for the slow LED blink; the fast blink uses bit BLINK_BIT-3.
REQ-004 The block SHALL have input clk_gen (1 bit): the clock-wizard output clock.
REQ-005 The block SHALL have input rst_n (1 bit): reset, asynchronous, active-low; clock clk_gen.
REQ-006 The block SHALL have input pll_locked_i (1 bit): clock-wizard lock, asynchronous to clk_gen.
REQ-007 The block SHALL have inputs boot_select_sw_i and exec_flash_sw_i (1 bit each): board switches, asynchronous.
REQ-008 The block SHALL have inputs exit_valid_i (1 bit) and exit_value_i (32 bits): SoC program-exit handshake.
REQ-009 The block SHALL have input restart_req_i (1 bit): single-cycle restart pulse.
REQ-010 The block SHALL have output soc_rst_no (1 bit): SoC reset, active-low, registered.
REQ-011 The block SHALL have outputs boot_select_o and execute_from_flash_o (1 bit each): latched boot straps.
REQ-012 The block SHALL have outputs exit_done_o (1 bit) and exit_value_o (32 bits): captured exit status.
REQ-013 The block SHALL have output status_led_o (1 bit): state indication.

Function
REQ-014 pll_locked_i and both switch inputs SHALL pass a 2-flop synchronizer, giving 2 cycles of latency.
REQ-015 The FSM SHALL have states WAIT_LOCK, HOLD, RUN and DONE, and SHALL enter WAIT_LOCK at reset.
REQ-016 WAIT_LOCK: the lock counter SHALL increment while synchronized lock is 1 and clear when it is 0; when the counter reaches LOCK_STABLE-1 with lock still 1, the FSM SHALL go to HOLD.
REQ-017 On entry to HOLD, the synchronized switch values SHALL be latched into boot_select_o and execute_from_flash_o; the straps SHALL NOT change at any other time.
REQ-018 HOLD SHALL last exactly RST_HOLD_CYCLES cycles, after which the FSM SHALL go to RUN; soc_rst_no SHALL be 1 from the first RUN cycle.
REQ-019 soc_rst_no SHALL be 0 in WAIT_LOCK and HOLD and 1 in RUN and DONE.
REQ-020 RUN: when exit_valid_i is sampled 1, exit_value_i SHALL be captured into exit_value_o, exit_done_o SHALL be set to 1, and the FSM SHALL go to DONE on the next edge.
REQ-021 DONE: exit_valid_i SHALL be ignored and exit_value_o SHALL hold its value.
REQ-022 Synchronized lock = 0 in any state other than WAIT_LOCK SHALL force the FSM to WAIT_LOCK on the next edge: soc_rst_no to 0 on that edge, lock counter cleared, exit_done_o cleared, exit_value_o kept.
REQ-023 Lock loss SHALL take priority over exit capture and over restart when they occur in the same cycle.
REQ-024 status_led_o SHALL be: 0 in WAIT_LOCK, 1 in HOLD, free-running counter bit BLINK_BIT in RUN; in DONE, 1 if exit_value_o==0, else counter bit BLINK_BIT-3.
REQ-025 The free-running counter SHALL be BLINK_BIT+1 bits wide and wrap silently.
REQ-026 The hold counter SHALL be $clog2(RST_HOLD_CYCLES+1) bits wide; the lock counter SHALL be $clog2(LOCK_STABLE+1) bits wide; neither counter SHALL wrap.

Reset
REQ-027 While rst_n is 0, outputs SHALL be: soc_rst_no=0, straps=0, exit_done_o=0, exit_value_o=0, status_led_o=0, all counters 0, synchronizer flops 0.
REQ-028 rst_n asserted in any state, including mid-HOLD, SHALL return the FSM to WAIT_LOCK asynchronously.

Configuration
REQ-029 With FPGA_SEQ_AUTO_RESTART_EN defined, restart_req_i=1 in DONE SHALL clear exit_done_o and exit_value_o and move the FSM to HOLD, re-latching the straps and reasserting soc_rst_no on the next edge.
REQ-030 Without FPGA_SEQ_AUTO_RESTART_EN, the restart_req_i port SHALL remain present but be ignored, and DONE SHALL be left only through lock loss or rst_n.

Structure
REQ-031 Package fpga_seq_pkg SHALL hold the FSM state enum (seq_state_e) and a default-parameter constant.
REQ-032 The 2-flop synchronizer SHALL be a sub-module, fpga_sync_2ff, with parameter RESET_VALUE and instantiated once per asynchronous input.

Verification
Benches use LOCK_STABLE=4, RST_HOLD_CYCLES=8, BLINK_BIT=4.
REQ-033 Lock raised and held -> HOLD entered 2+4 cycles later; soc_rst_no goes 1 exactly 8 cycles after HOLD entry.
REQ-034 Lock glitches low for 1 cycle after 3 high cycles -> counter clears; HOLD is entered only after 4 fresh consecutive highs.
REQ-035 Switches=1/0 at HOLD entry, then toggled in RUN -> boot_select_o=1 and execute_from_flash_o=0 remain unchanged.
REQ-036 exit_valid_i=1 with exit_value_i=0 -> exit_done_o=1 and LED solid 1; with 0x0000_0005 -> LED follows counter bit 1.
REQ-037 Lock dropped in RUN in the same cycle as exit_valid_i -> WAIT_LOCK, soc_rst_no=0, exit_done_o=0.
REQ-038 Macro defined, restart pulse in DONE -> soc_rst_no=0 for 8 cycles, then 1; macro undefined -> the FSM stays in DONE.

Source files
------------

// File: rtl/fpga_seq_pkg.sv
// Shared types and defaults for the FPGA reset/boot sequencer.
package fpga_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2,
    DONE      = 2'd3
  } seq_state_e;

  localparam int DEF_LOCK_STABLE     = 16;
  localparam int DEF_RST_HOLD_CYCLES = 1024;
  localparam int DEF_BLINK_BIT       = 24;

  // The SoC is out of reset only once the hold window has completed.
  function automatic logic soc_released(input seq_state_e s);
    return (s == RUN) || (s == DONE);
  endfunction

endpackage

// File: rtl/fpga_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module fpga_sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Metastability filter: first stage may go metastable, second resolves it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fpga_rst_boot_seq.sv
// Board-level boot sequencer: qualifies PLL lock, holds SoC reset, latches straps,
// and captures the program exit status. FPGA_SEQ_AUTO_RESTART_EN enables restart from DONE.
module fpga_rst_boot_seq
  import fpga_seq_pkg::*;
#(
  parameter int LOCK_STABLE     = DEF_LOCK_STABLE,
  parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int BLINK_BIT       = DEF_BLINK_BIT
) (
  input  logic        clk_gen,
  input  logic        rst_n,
  input  logic        pll_locked_i,
  input  logic        boot_select_sw_i,
  input  logic        exec_flash_sw_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  input  logic        restart_req_i,
  output logic        soc_rst_no,
  output logic        boot_select_o,
  output logic        execute_from_flash_o,
  output logic        exit_done_o,
  output logic [31:0] exit_value_o,
  output logic        status_led_o
);

  localparam int LOCK_W = $clog2(LOCK_STABLE + 1);
  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam int FREE_W = BLINK_BIT + 1;

  logic lock_s;
  logic boot_sw_s;
  logic flash_sw_s;

  fpga_sync_2ff #(.RESET_VALUE(1'b0)) u_sync_lock (
    .clk_i(clk_gen), .rst_ni(rst_n), .d_i(pll_locked_i), .q_o(lock_s)
  );
  fpga_sync_2ff #(.RESET_VALUE(1'b0)) u_sync_boot (
    .clk_i(clk_gen), .rst_ni(rst_n), .d_i(boot_select_sw_i), .q_o(boot_sw_s)
  );
  fpga_sync_2ff #(.RESET_VALUE(1'b0)) u_sync_flash (
    .clk_i(clk_gen), .rst_ni(rst_n), .d_i(exec_flash_sw_i), .q_o(flash_sw_s)
  );

`ifndef FPGA_SEQ_AUTO_RESTART_EN
  logic unused_restart_s;
  assign unused_restart_s = restart_req_i;
`endif

  seq_state_e        state_q, state_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [FREE_W-1:0] free_cnt_q, free_cnt_d;
  logic              soc_rst_n_q, soc_rst_n_d;
  logic              boot_q, boot_d;
  logic              flash_q, flash_d;
  logic              exit_done_q, exit_done_d;
  logic [31:0]       exit_value_q, exit_value_d;
  logic              led_q, led_d;

  // Sequencer state and every registered output.
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_LOCK;
      lock_cnt_q   <= {LOCK_W{1'b0}};
      hold_cnt_q   <= {HOLD_W{1'b0}};
      free_cnt_q   <= {FREE_W{1'b0}};
      soc_rst_n_q  <= 1'b0;
      boot_q       <= 1'b0;
      flash_q      <= 1'b0;
      exit_done_q  <= 1'b0;
      exit_value_q <= 32'd0;
      led_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      free_cnt_q   <= free_cnt_d;
      soc_rst_n_q  <= soc_rst_n_d;
      boot_q       <= boot_d;
      flash_q      <= flash_d;
      exit_done_q  <= exit_done_d;
      exit_value_q <= exit_value_d;
      led_q        <= led_d;
    end
  end

  // Next-state logic; lock loss is applied last so it overrides exit and restart.
  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    free_cnt_d   = free_cnt_q + {{(FREE_W-1){1'b0}}, 1'b1};
    boot_d       = boot_q;
    flash_d      = flash_q;
    exit_done_d  = exit_done_q;
    exit_value_d = exit_value_q;
    led_d        = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        hold_cnt_d = {HOLD_W{1'b0}};
        if (!lock_s) begin
          lock_cnt_d = {LOCK_W{1'b0}};
        end else if (lock_cnt_q == LOCK_W'(LOCK_STABLE - 1)) begin
          state_d    = HOLD;
          lock_cnt_d = {LOCK_W{1'b0}};
        end else begin
          lock_cnt_d = lock_cnt_q + {{(LOCK_W-1){1'b0}}, 1'b1};
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_W'(RST_HOLD_CYCLES - 1)) begin
          state_d    = RUN;
          hold_cnt_d = {HOLD_W{1'b0}};
        end else begin
          hold_cnt_d = hold_cnt_q + {{(HOLD_W-1){1'b0}}, 1'b1};
        end
      end
      RUN: begin
        if (exit_valid_i) begin
          state_d      = DONE;
          exit_done_d  = 1'b1;
          exit_value_d = exit_value_i;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
`ifdef FPGA_SEQ_AUTO_RESTART_EN
        if (restart_req_i) begin
          state_d      = HOLD;
          hold_cnt_d   = {HOLD_W{1'b0}};
          exit_done_d  = 1'b0;
          exit_value_d = 32'd0;
        end else begin
          state_d = DONE;
        end
`else
        state_d = DONE;
`endif
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase

    if (!lock_s && (state_q != WAIT_LOCK)) begin
      state_d      = WAIT_LOCK;
      lock_cnt_d   = {LOCK_W{1'b0}};
      hold_cnt_d   = {HOLD_W{1'b0}};
      exit_done_d  = 1'b0;
      exit_value_d = exit_value_q;
    end else begin
      state_d = state_d;
    end

    // Straps are sampled only on the edge that enters HOLD.
    if ((state_d == HOLD) && (state_q != HOLD)) begin
      boot_d  = boot_sw_s;
      flash_d = flash_sw_s;
    end else begin
      boot_d  = boot_d;
      flash_d = flash_d;
    end

    case (state_d)
      WAIT_LOCK: led_d = 1'b0;
      HOLD:      led_d = 1'b1;
      RUN:       led_d = free_cnt_d[BLINK_BIT];
      DONE:      led_d = (exit_value_d == 32'd0) ? 1'b1 : free_cnt_d[BLINK_BIT-3];
      default:   led_d = 1'b0;
    endcase
  end

  assign soc_rst_n_d          = soc_released(state_d);
  assign soc_rst_no           = soc_rst_n_q;
  assign boot_select_o        = boot_q;
  assign execute_from_flash_o = flash_q;
  assign exit_done_o          = exit_done_q;
  assign exit_value_o         = exit_value_q;
  assign status_led_o         = led_q;

endmodule

// File: tb/tb_fpga_rst_boot_seq.sv
// Directed, scoreboard-driven bench for fpga_rst_boot_seq (LOCK_STABLE=4, RST_HOLD_CYCLES=8, BLINK_BIT=4).
module tb_fpga_rst_boot_seq;

  localparam int LS = 4;
  localparam int HC = 8;
  localparam int BB = 4;

  localparam int S_RST = 0, S_BOOT = 1, S_FLASH = 2, S_DONE = 3, S_VAL = 4, S_LED = 5;

  logic        clk_gen = 1'b0;
  logic        rst_n;
  logic        pll_locked_i;
  logic        boot_select_sw_i;
  logic        exec_flash_sw_i;
  logic        exit_valid_i;
  logic [31:0] exit_value_i;
  logic        restart_req_i;
  logic        soc_rst_no;
  logic        boot_select_o;
  logic        execute_from_flash_o;
  logic        exit_done_o;
  logic [31:0] exit_value_o;
  logic        status_led_o;

  typedef struct {
    int          due;
    int          sig;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   rel      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk_gen = ~clk_gen;

  fpga_rst_boot_seq #(
    .LOCK_STABLE(LS), .RST_HOLD_CYCLES(HC), .BLINK_BIT(BB)
  ) dut (
    .clk_gen(clk_gen), .rst_n(rst_n), .pll_locked_i(pll_locked_i),
    .boot_select_sw_i(boot_select_sw_i), .exec_flash_sw_i(exec_flash_sw_i),
    .exit_valid_i(exit_valid_i), .exit_value_i(exit_value_i),
    .restart_req_i(restart_req_i), .soc_rst_no(soc_rst_no),
    .boot_select_o(boot_select_o), .execute_from_flash_o(execute_from_flash_o),
    .exit_done_o(exit_done_o), .exit_value_o(exit_value_o),
    .status_led_o(status_led_o)
  );

  function automatic logic [31:0] observe(input int sig);
    logic [31:0] v;
    v = 32'hDEAD_BEEF;
    case (sig)
      S_RST:   v = {31'd0, soc_rst_no};
      S_BOOT:  v = {31'd0, boot_select_o};
      S_FLASH: v = {31'd0, execute_from_flash_o};
      S_DONE:  v = {31'd0, exit_done_o};
      S_VAL:   v = exit_value_o;
      S_LED:   v = {31'd0, status_led_o};
      default: v = 32'hDEAD_BEEF;
    endcase
    return v;
  endfunction

  // Free-running counter model: value after cycle d is d - rel since reset release.
  function automatic logic [31:0] cnt_bit(input int d, input int b);
    return 32'(((d - rel) >> b) & 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_at(input int due, input int sig, input logic [31:0] exp, input string tag);
    exp_t e;
    e.due = due; e.sig = sig; e.exp = exp; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].tag, observe(sb[i].sig), sb[i].exp);
        sb.delete(i);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_gen);
      #1;
      cyc++;
      drain();
    end
  endtask

  // Drop lock from RUN/DONE, optionally with a simultaneous exit, then reacquire into RUN.
  task automatic relock(input logic boot, input logic flash, input logic with_exit,
                        input logic [31:0] kept_val);
    int z;
    int c;
    z = cyc;
    pll_locked_i     = 1'b0;
    boot_select_sw_i = boot;
    exec_flash_sw_i  = flash;
    expect_at(z + 2, S_RST, 32'd1, "rst_before_loss");
    expect_at(z + 3, S_RST, 32'd0, "rst_on_loss");
    expect_at(z + 3, S_DONE, 32'd0, "done_cleared_on_loss");
    expect_at(z + 3, S_VAL, kept_val, "value_kept_on_loss");
    expect_at(z + 3, S_LED, 32'd0, "led_wait_lock_on_loss");
    step(2);
    exit_valid_i = with_exit;
    exit_value_i = 32'h0000_000A;
    step(1);
    exit_valid_i = 1'b0;
    step(1);
    c = cyc;
    pll_locked_i = 1'b1;
    expect_at(c + 5, S_LED, 32'd0, "led_before_hold");
    expect_at(c + 6, S_LED, 32'd1, "led_hold_entry");
    expect_at(c + 6, S_BOOT, {31'd0, boot}, "boot_relatched");
    expect_at(c + 6, S_FLASH, {31'd0, flash}, "flash_relatched");
    expect_at(c + 13, S_RST, 32'd0, "rst_held_last");
    expect_at(c + 14, S_RST, 32'd1, "rst_released");
    step(14);
  endtask

  initial begin
    int c0;
    int x;
    int e;
    int c;
    int r;

    rst_n            = 1'b0;
    pll_locked_i     = 1'b0;
    boot_select_sw_i = 1'b0;
    exec_flash_sw_i  = 1'b0;
    exit_valid_i     = 1'b0;
    exit_value_i     = 32'd0;
    restart_req_i    = 1'b0;
    step(3);
    for (int s = 0; s < 6; s++) check("reset_state", observe(s), 32'd0);

    rst_n = 1'b1;
    rel   = cyc;

    // Glitched lock: three highs, one low, then fresh highs.
    boot_select_sw_i = 1'b1;
    exec_flash_sw_i  = 1'b0;
    c0 = cyc;
    pll_locked_i = 1'b1;
    expect_at(c0 + 6, S_LED, 32'd0, "glitch_no_early_hold");
    expect_at(c0 + 9, S_LED, 32'd0, "glitch_wait_lock");
    expect_at(c0 + 9, S_BOOT, 32'd0, "strap_not_early");
    expect_at(c0 + 10, S_LED, 32'd1, "glitch_hold_entry");
    expect_at(c0 + 10, S_BOOT, 32'd1, "boot_latched");
    expect_at(c0 + 10, S_FLASH, 32'd0, "flash_latched");
    expect_at(c0 + 17, S_RST, 32'd0, "hold_last_cycle");
    expect_at(c0 + 18, S_RST, 32'd1, "hold_released");
    expect_at(c0 + 18, S_LED, cnt_bit(c0 + 18, BB), "led_run_blink");
    step(3);
    pll_locked_i = 1'b0;
    step(1);
    pll_locked_i = 1'b1;
    step(14);

    // Straps must ignore switch changes while running.
    boot_select_sw_i = 1'b0;
    exec_flash_sw_i  = 1'b1;
    expect_at(cyc + 4, S_BOOT, 32'd1, "boot_stable_in_run");
    expect_at(cyc + 4, S_FLASH, 32'd0, "flash_stable_in_run");
    expect_at(cyc + 4, S_LED, cnt_bit(cyc + 4, BB), "led_run_blink2");
    step(4);

    // Exit with zero, then a second exit that DONE must ignore.
    exit_valid_i = 1'b1;
    exit_value_i = 32'd0;
    expect_at(cyc + 1, S_DONE, 32'd1, "exit_done_set");
    expect_at(cyc + 1, S_VAL, 32'd0, "exit_value_zero");
    expect_at(cyc + 1, S_LED, 32'd1, "led_done_solid");
    step(1);
    exit_value_i = 32'h0000_0099;
    expect_at(cyc + 2, S_VAL, 32'd0, "done_ignores_exit");
    expect_at(cyc + 2, S_DONE, 32'd1, "done_holds");
    expect_at(cyc + 2, S_LED, 32'd1, "led_still_solid");
    step(1);
    exit_valid_i = 1'b0;
    step(1);

    // Restart pulse in DONE.
    restart_req_i = 1'b1;
    x = cyc;
`ifdef FPGA_SEQ_AUTO_RESTART_EN
    expect_at(x + 1, S_RST, 32'd0, "restart_rst_asserted");
    expect_at(x + 1, S_DONE, 32'd0, "restart_done_cleared");
    expect_at(x + 1, S_LED, 32'd1, "restart_led_hold");
    expect_at(x + 1, S_BOOT, 32'd0, "restart_boot_relatched");
    expect_at(x + 1, S_FLASH, 32'd1, "restart_flash_relatched");
    expect_at(x + 8, S_RST, 32'd0, "restart_hold_last");
    expect_at(x + 9, S_RST, 32'd1, "restart_released");
`else
    expect_at(x + 1, S_RST, 32'd1, "no_restart_rst");
    expect_at(x + 1, S_DONE, 32'd1, "no_restart_done");
    expect_at(x + 1, S_BOOT, 32'd1, "no_restart_boot");
    expect_at(x + 1, S_FLASH, 32'd0, "no_restart_flash");
    expect_at(x + 9, S_RST, 32'd1, "no_restart_stays");
    expect_at(x + 9, S_LED, 32'd1, "no_restart_led");
`endif
    step(1);
    restart_req_i = 1'b0;
    step(8);

    // Clean reacquire, then exit with a nonzero value.
    relock(1'b1, 1'b1, 1'b0, 32'd0);
    exit_valid_i = 1'b1;
    exit_value_i = 32'h0000_0005;
    e = cyc;
    expect_at(e + 1, S_DONE, 32'd1, "exit5_done");
    expect_at(e + 1, S_VAL, 32'h0000_0005, "exit5_value");
    for (int k = 1; k <= 5; k++) expect_at(e + k, S_LED, cnt_bit(e + k, BB - 3), "led_done_fast_blink");
    step(1);
    exit_valid_i = 1'b0;
    step(5);

    // Lock loss from DONE, then lock loss colliding with an exit in RUN.
    relock(1'b0, 1'b0, 1'b0, 32'h0000_0005);
    relock(1'b1, 1'b0, 1'b1, 32'h0000_0005);
    expect_at(cyc + 1, S_VAL, 32'h0000_0005, "value_kept_after_relock");
    expect_at(cyc + 1, S_DONE, 32'd0, "done_clear_after_relock");
    step(1);

    // Asynchronous reset mid-HOLD.
    boot_select_sw_i = 1'b1;
    exec_flash_sw_i  = 1'b1;
    pll_locked_i     = 1'b0;
    step(4);
    c = cyc;
    pll_locked_i = 1'b1;
    expect_at(c + 6, S_LED, 32'd1, "hold_before_reset");
    expect_at(c + 6, S_FLASH, 32'd1, "flash_before_reset");
    step(8);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_soc", observe(S_RST), 32'd0);
    check("async_rst_led", observe(S_LED), 32'd0);
    check("async_rst_boot", observe(S_BOOT), 32'd0);
    check("async_rst_flash", observe(S_FLASH), 32'd0);
    check("async_rst_done", observe(S_DONE), 32'd0);
    check("async_rst_value", observe(S_VAL), 32'd0);
    step(2);
    rst_n = 1'b1;
    rel   = cyc;
    r     = cyc;
    expect_at(r + 5, S_LED, 32'd0, "post_reset_wait");
    expect_at(r + 6, S_LED, 32'd1, "post_reset_hold");
    expect_at(r + 6, S_BOOT, 32'd1, "post_reset_boot");
    expect_at(r + 13, S_RST, 32'd0, "post_reset_held");
    expect_at(r + 14, S_RST, 32'd1, "post_reset_released");
    expect_at(r + 14, S_LED, cnt_bit(r + 14, BB), "post_reset_blink");
    step(16);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
